// File: rtl/memory_access_stage.sv
// memory_access_stage: load/store stage with an IDLE/ACCESS/DONE data-bus handshake.
// Define MEMORY_ACCESS_TIMEOUT_EN to abort a bus wait after TIMEOUT_CYCLES cycles in ACCESS.
module memory_access_stage #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ex_valid,
   output logic                     ex_ready,
   input  logic [31:0]              alu_out,
   input  logic [31:0]              store_data,
   input  logic                     mem_read,
   input  logic                     mem_write,
   input  logic [2:0]               funct3,
   input  logic [4:0]               rd_addr,
   input  logic                     reg_write,
   output logic                     dmem_req,
   output logic                     dmem_we,
   output logic [ADDRESS_WIDTH-1:0] dmem_addr,
   output logic [3:0]               dmem_wstrb,
   output logic [31:0]              dmem_wdata,
   input  logic                     dmem_ack,
   input  logic [31:0]              dmem_rdata,
   output logic                     wb_valid,
   output logic [4:0]               wb_rd,
   output logic [31:0]              wb_data,
   output logic                     wb_reg_write,
   output logic                     mem_exception
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state;
   logic [2:0] f3_q;
   logic [1:0] off_q;
   logic rw_q, is_mem, bad_f3, misaligned, err;
   logic [7:0] lane;
   logic [15:0] half;
   logic [31:0] load_data, st_wdata;
   logic [3:0] st_wstrb;
`ifdef MEMORY_ACCESS_TIMEOUT_EN
   logic [7:0] wait_cnt;
`endif

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
   end

   assign ex_ready = state == IDLE;
   assign is_mem = mem_read | mem_write;
   assign bad_f3 = (mem_read & mem_write) |
                   (mem_read ? (funct3 == 3'b011 || funct3[2:1] == 2'b11) : funct3 >= 3'b011);
   assign misaligned = (funct3[1:0] == 2'b01 && alu_out[0]) ||
                       (funct3[1:0] == 2'b10 && alu_out[1:0] != 2'b00);
   assign err = is_mem & (bad_f3 | misaligned);
   assign st_wstrb = funct3[1:0] == 2'b00 ? 4'b0001 << alu_out[1:0] :
                     funct3[1:0] == 2'b01 ? (alu_out[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign st_wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
   assign lane = 8'(dmem_rdata >> {off_q, 3'b000});
   assign half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
   assign load_data = f3_q == 3'b000 ? {{24{lane[7]}}, lane} :
                      f3_q == 3'b001 ? {{16{half[15]}}, half} :
                      f3_q == 3'b100 ? {24'b0, lane} :
                      f3_q == 3'b101 ? {16'b0, half} : dmem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         dmem_req <= 1'b0;
         dmem_we <= 1'b0;
         dmem_addr <= '0;
         dmem_wstrb <= '0;
         dmem_wdata <= '0;
         wb_valid <= 1'b0;
         wb_rd <= '0;
         wb_data <= '0;
         wb_reg_write <= 1'b0;
         mem_exception <= 1'b0;
         f3_q <= '0;
         off_q <= '0;
         rw_q <= 1'b0;
`ifdef MEMORY_ACCESS_TIMEOUT_EN
         wait_cnt <= '0;
`endif
      end else begin
         wb_valid <= 1'b0;
         mem_exception <= 1'b0;
         case (state)
            IDLE:
               if (ex_valid) begin
                  wb_rd <= rd_addr;
                  if (is_mem && !err) begin
                     state <= ACCESS;
                     dmem_req <= 1'b1;
                     dmem_we <= mem_write;
                     dmem_addr <= ADDRESS_WIDTH'({alu_out[31:2], 2'b00});
                     dmem_wstrb <= mem_write ? st_wstrb : 4'b0000;
                     dmem_wdata <= mem_write ? st_wdata : 32'h0;
                     f3_q <= funct3;
                     off_q <= alu_out[1:0];
                     rw_q <= mem_read & reg_write & (rd_addr != 5'd0);
`ifdef MEMORY_ACCESS_TIMEOUT_EN
                     wait_cnt <= '0;
`endif
                  end else begin
                     // ALU results and rejected accesses write back straight from IDLE
                     wb_valid <= 1'b1;
                     mem_exception <= err;
                     wb_data <= err ? 32'h0 : alu_out;
                     wb_reg_write <= !err & reg_write & (rd_addr != 5'd0);
                  end
               end
            ACCESS:
               if (dmem_ack) begin
                  state <= DONE;
                  dmem_req <= 1'b0;
                  dmem_we <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_data <= dmem_we ? 32'h0 : load_data;
                  wb_reg_write <= rw_q;
               end
`ifdef MEMORY_ACCESS_TIMEOUT_EN
               else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  state <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we <= 1'b0;
                  wb_valid <= 1'b1;
                  mem_exception <= 1'b1;
                  wb_reg_write <= 1'b0;
               end else
                  wait_cnt <= wait_cnt + 8'd1;
`endif
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed table plus randomized transactions against a behavioural model.
module tb_memory_access_stage;
   logic clk = 1'b0;
   logic rst_n, ex_valid, ex_ready, mem_read, mem_write, reg_write;
   logic [31:0] alu_out, store_data, dmem_rdata, dmem_wdata, wb_data;
   logic [2:0] funct3;
   logic [4:0] rd_addr, wb_rd;
   logic dmem_req, dmem_we, dmem_ack, wb_valid, wb_reg_write, mem_exception;
   logic [31:0] dmem_addr;
   logic [3:0] dmem_wstrb;

   always #5 clk = ~clk;

   memory_access_stage #(.TIMEOUT_CYCLES(4), .ADDRESS_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_out(alu_out), .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .rd_addr(rd_addr), .reg_write(reg_write),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
      .mem_exception(mem_exception)
   );

   typedef struct {
      logic rd, wr;
      logic [2:0] f3;
      logic [31:0] alu, sd, rdata;
      logic [4:0] dst;
      logic rw;
      int wt;
      logic exc;
      logic [31:0] data;
      logic exp_rw;
      logic [3:0] strb;
      logic [31:0] wdata;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;
   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic rd, wr, input logic [2:0] f3, input logic [31:0] alu, sd,
                               rdata, input logic [4:0] dst, input logic rw, input int wt,
                               input logic exc, input logic [31:0] data, input logic exp_rw,
                               input logic [3:0] strb, input logic [31:0] wdata);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.alu = alu; v.sd = sd; v.rdata = rdata;
      v.dst = dst; v.rw = rw; v.wt = wt; v.exc = exc; v.data = data; v.exp_rw = exp_rw;
      v.strb = strb; v.wdata = wdata;
      return v;
   endfunction

   // Expected behaviour from access size, byte offset and the RV32 load/store rules
   function automatic vec_t model(input vec_t v);
      int size, off;
      logic [31:0] mask;
      off = int'(v.alu % 32'd4);
      size = v.f3[1:0] == 2'd0 ? 1 : v.f3[1:0] == 2'd1 ? 2 : v.f3[1:0] == 2'd2 ? 4 : 0;
      v.strb = '0; v.wdata = '0; v.data = '0; v.exc = 1'b0; v.exp_rw = 1'b0;
      if (!v.rd && !v.wr) begin
         v.data = v.alu;
         v.exp_rw = v.rw && v.dst != 0;
         return v;
      end
      v.exc = v.rd == v.wr || size == 0 || (v.wr && v.f3 > 3'd3) || (v.rd && v.f3 > 3'd5);
      if (!v.exc && v.alu % 32'(size) != 0) v.exc = 1'b1;
      if (v.exc) return v;
      mask = size == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
      if (v.rd) begin
         v.data = (v.rdata >> (8 * off)) & mask;
         if (!v.f3[2] && size < 4 && v.data[8 * size - 1]) v.data = v.data | ~mask;
         v.exp_rw = v.rw && v.dst != 0;
      end else begin
         v.strb = 4'(((32'd1 << size) - 32'd1) << off);
         v.wdata = (v.sd & mask) * (size == 1 ? 32'h0101_0101 : size == 2 ? 32'h0001_0001 : 32'd1);
      end
      return v;
   endfunction

   task automatic run(input vec_t v);
      ex_valid = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; alu_out = v.alu;
      store_data = v.sd; rd_addr = v.dst; reg_write = v.rw;
      chk("accept_ready", ex_ready, 1);
      step();
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      if ((!v.rd && !v.wr) || v.exc) begin
         chk("direct_wb_valid", wb_valid, 1);
         chk("direct_exception", mem_exception, v.exc);
         chk("direct_no_req", dmem_req, 0);
         chk("direct_reg_write", wb_reg_write, v.exp_rw);
         chk("direct_wb_rd", wb_rd, v.dst);
         chk("direct_ready", ex_ready, 1);
         if (!v.rd && !v.wr) chk("alu_wb_data", wb_data, v.data);
      end else begin
         chk("req", dmem_req, 1);
         chk("addr", dmem_addr, v.alu & 32'hFFFF_FFFC);
         chk("we", dmem_we, v.wr);
         chk("busy", ex_ready, 0);
         chk("no_early_wb", wb_valid, 0);
         if (v.wr) begin
            chk("wstrb", dmem_wstrb, v.strb);
            chk("wdata", dmem_wdata, v.wdata);
         end
         repeat (v.wt) begin
            step();
            chk("req_hold", dmem_req, 1);
            chk("addr_hold", dmem_addr, v.alu & 32'hFFFF_FFFC);
         end
         dmem_ack = 1'b1; dmem_rdata = v.rdata;
         step();
         dmem_ack = 1'b0; dmem_rdata = $urandom;
         chk("done_wb_valid", wb_valid, 1);
         chk("done_req_drop", dmem_req, 0);
         chk("done_no_exc", mem_exception, 0);
         chk("done_reg_write", wb_reg_write, v.exp_rw);
         chk("done_wb_rd", wb_rd, v.dst);
         if (v.rd) chk("load_data", wb_data, v.data);
         step();
         chk("wb_pulse_end", wb_valid, 0);
         chk("back_to_idle", ex_ready, 1);
      end
   endtask

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
      alu_out = '0; store_data = '0; rd_addr = '0; reg_write = 1'b0; dmem_ack = 1'b0;
      dmem_rdata = '0;
      //        rd wr f3    alu           sd            rdata         dst rw wt exc data          erw strb     wdata
      tbl[0]  = mk(0, 0, 3'd0, 32'h1234,     32'h0,        32'h0,        5,  1, 0, 0, 32'h1234,     1, 4'b0000, 32'h0);
      tbl[1]  = mk(0, 0, 3'd0, 32'hBEEF,     32'h0,        32'h0,        0,  1, 0, 0, 32'hBEEF,     0, 4'b0000, 32'h0);
      tbl[2]  = mk(1, 0, 3'd0, 32'h103,      32'h0,        32'h80FF_0000, 7, 1, 2, 0, 32'hFFFF_FF80, 1, 4'b0000, 32'h0);
      tbl[3]  = mk(0, 1, 3'd1, 32'h202,      32'hABCD_1234, 32'h0,       9,  1, 1, 0, 32'h0,        0, 4'b1100, 32'h1234_1234);
      tbl[4]  = mk(1, 0, 3'd2, 32'h101,      32'h0,        32'h0,        4,  1, 0, 1, 32'h0,        0, 4'b0000, 32'h0);
      tbl[5]  = mk(1, 0, 3'd4, 32'h102,      32'h0,        32'h12F4_5678, 6, 1, 0, 0, 32'h0000_00F4, 1, 4'b0000, 32'h0);
      tbl[6]  = mk(1, 0, 3'd1, 32'h102,      32'h0,        32'h8001_7FFF, 8, 1, 3, 0, 32'hFFFF_8001, 1, 4'b0000, 32'h0);
      tbl[7]  = mk(1, 0, 3'd5, 32'h100,      32'h0,        32'h8001_F00D, 8, 1, 0, 0, 32'h0000_F00D, 1, 4'b0000, 32'h0);
      tbl[8]  = mk(1, 0, 3'd2, 32'h200,      32'h0,        32'hDEAD_BEEF, 0, 1, 1, 0, 32'hDEAD_BEEF, 0, 4'b0000, 32'h0);
      tbl[9]  = mk(0, 1, 3'd0, 32'h301,      32'h1122_3355, 32'h0,       2,  1, 0, 0, 32'h0,        0, 4'b0010, 32'h5555_5555);
      tbl[10] = mk(0, 1, 3'd2, 32'h304,      32'hCAFE_F00D, 32'h0,       3,  0, 2, 0, 32'h0,        0, 4'b1111, 32'hCAFE_F00D);
      tbl[11] = mk(1, 0, 3'd3, 32'h0,        32'h0,        32'h0,        1,  1, 0, 1, 32'h0,        0, 4'b0000, 32'h0);
      tbl[12] = mk(0, 1, 3'd4, 32'h0,        32'h0,        32'h0,        1,  1, 0, 1, 32'h0,        0, 4'b0000, 32'h0);
      tbl[13] = mk(1, 1, 3'd2, 32'h0,        32'h0,        32'h0,        1,  1, 0, 1, 32'h0,        0, 4'b0000, 32'h0);
      tbl[14] = mk(1, 0, 3'd1, 32'h101,      32'h0,        32'h0,        1,  1, 0, 1, 32'h0,        0, 4'b0000, 32'h0);
      tbl[15] = mk(1, 0, 3'd6, 32'h0,        32'h0,        32'h0,        1,  1, 0, 1, 32'h0,        0, 4'b0000, 32'h0);
      #12;
      chk("rst_ready", ex_ready, 1);
      chk("rst_req", dmem_req, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_exc", mem_exception, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_addr", dmem_addr, 0);
      #10 rst_n = 1'b1;
      step();
      for (int i = 0; i < 16; i++) run(tbl[i]);
      for (int i = 0; i < 150; i++) begin
         vec_t v;
         int k;
         k = $urandom_range(0, 9);
         v = mk(k >= 3 && k <= 5 || k == 9, k >= 6, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3), 0, 0, 0, 0, 0);
         run(model(v));
      end
      step();
      chk("idle_quiet", wb_valid, 0);
      // Reset in the middle of a bus wait, followed by a stale acknowledge
      ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; alu_out = 32'h400; rd_addr = 5'd3;
      reg_write = 1'b1;
      step();
      ex_valid = 1'b0; mem_read = 1'b0;
      chk("rst_access_req", dmem_req, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_req_drop", dmem_req, 0);
      chk("async_ready", ex_ready, 1);
      chk("async_wb_valid", wb_valid, 0);
      #2 rst_n = 1'b1;
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      chk("late_ack_no_wb", wb_valid, 0);
      chk("late_ack_no_req", dmem_req, 0);
      chk("late_ack_ready", ex_ready, 1);
      chk("late_ack_no_exc", mem_exception, 0);
      ex_valid = 1'b1; mem_write = 1'b1; funct3 = 3'd2; alu_out = 32'h600; store_data = 32'h5A5A_5A5A;
      step();
      ex_valid = 1'b0; mem_write = 1'b0;
      chk("wait_req", dmem_req, 1);
`ifdef MEMORY_ACCESS_TIMEOUT_EN
      repeat (3) begin
         step();
         chk("timeout_hold", dmem_req, 1);
      end
      step();
      chk("timeout_req_drop", dmem_req, 0);
      chk("timeout_wb_valid", wb_valid, 1);
      chk("timeout_exc", mem_exception, 1);
      chk("timeout_reg_write", wb_reg_write, 0);
      chk("timeout_idle", ex_ready, 1);
      step();
      chk("timeout_pulse_end", mem_exception, 0);
`else
      repeat (20) begin
         step();
         chk("long_wait_hold", dmem_req, 1);
         chk("long_wait_no_exc", mem_exception, 0);
      end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      chk("long_wait_wb", wb_valid, 1);
      chk("long_wait_store_rw", wb_reg_write, 0);
      step();
      chk("long_wait_idle", ex_ready, 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
